// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue/retire controller for a small external ALU. Holds a 4 x N register
//   file (r0-r3) and a {V,C,N,Z} flags register, accepts one instruction at a
//   time and steps it through IDLE -> EXEC -> WB. LDI and illegal opcodes skip
//   EXEC and retire directly from WB.
//
//   Optional feature: define ALU_CARRY_CHAIN_EN to drive alu_cin from the
//   architectural C flag during EXEC of ADD (op 0). Undefined: alu_cin = 0.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready  instruction handshake (ready only in IDLE)
//   instr_op[4:0]              0 ADD, 1 SUB, 2-14 ALU ops, 31 LDI, 15-30 illegal
//   instr_rd/rs1/rs2[1:0]      destination / source register indices
//   instr_imm[N-1:0]           LDI immediate
//   alu_op, alu_a, alu_b, alu_cin   operands to the external ALU (valid in EXEC)
//   alu_res, alu_v/c/n/z       result and flags returned by the ALU
//   done, err                  one-cycle retire pulse; err marks an illegal op
//   flags[3:0]                 architectural flags {V,C,N,Z}
//   dbg_addr / dbg_data        combinational register file read port
module alu_issue_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [4:0]   instr_op,
  input  logic [1:0]   instr_rd,
  input  logic [1:0]   instr_rs1,
  input  logic [1:0]   instr_rs2,
  input  logic [N-1:0] instr_imm,
  output logic [4:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  input  logic [N-1:0] alu_res,
  input  logic         alu_v,
  input  logic         alu_c,
  input  logic         alu_n,
  input  logic         alu_z,
  output logic         done,
  output logic         err,
  output logic [3:0]   flags,
  input  logic [1:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
  localparam logic [4:0] OP_ALU_MAX = 5'd14;
  localparam logic [4:0] OP_LDI     = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t       state_reg;
  logic [N-1:0] rf_reg [4];
  logic [3:0]   flags_reg;

  // Instruction fields latched at acceptance
  logic [4:0]   op_reg;
  logic [1:0]   rd_reg;
  logic [N-1:0] imm_reg;

  // ALU results captured at the end of EXEC
  logic [N-1:0] res_reg;
  logic [3:0]   res_flags_reg;

  logic [4:0]   alu_op_reg;
  logic [N-1:0] alu_a_reg;
  logic [N-1:0] alu_b_reg;
  logic         alu_cin_reg;
  logic         done_reg;
  logic         err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      for (int i = 0; i < 4; i++) rf_reg[i] <= '0;
      flags_reg     <= 4'd0;
      op_reg        <= 5'd0;
      rd_reg        <= 2'd0;
      imm_reg       <= '0;
      res_reg       <= '0;
      res_flags_reg <= 4'd0;
      alu_op_reg    <= 5'd0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_cin_reg   <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            op_reg  <= instr_op;
            rd_reg  <= instr_rd;
            imm_reg <= instr_imm;
            if (instr_op <= OP_ALU_MAX) begin
              // Operands are sampled here, so rd == rs1/rs2 sees the old value
              state_reg  <= EXEC;
              alu_op_reg <= instr_op;
              alu_a_reg  <= rf_reg[instr_rs1];
              alu_b_reg  <= rf_reg[instr_rs2];
`ifdef ALU_CARRY_CHAIN_EN
              // Flags cannot change before EXEC, so sampling C now is exact
              alu_cin_reg <= (instr_op == OP_ADD) && flags_reg[2];
`else
              alu_cin_reg <= 1'b0;
`endif
            end else begin
              state_reg <= WB;
              done_reg  <= 1'b1;
              err_reg   <= (instr_op != OP_LDI);
            end
          end
        end
        EXEC: begin
          res_reg       <= alu_res;
          res_flags_reg <= {alu_v, alu_c, alu_n, alu_z};
          alu_op_reg    <= 5'd0;
          alu_a_reg     <= '0;
          alu_b_reg     <= '0;
          alu_cin_reg   <= 1'b0;
          done_reg      <= 1'b1;
          state_reg     <= WB;
        end
        WB: begin
          state_reg <= IDLE;
          if (op_reg <= OP_ALU_MAX) begin
            rf_reg[rd_reg] <= res_reg;
            if (op_reg == OP_ADD || op_reg == OP_SUB) flags_reg <= res_flags_reg;
          end else if (op_reg == OP_LDI) begin
            rf_reg[rd_reg] <= imm_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Ready is gated by rst_n so it reads 0 for the whole reset interval
  assign instr_ready = rst_n && (state_reg == IDLE);
  assign alu_op      = alu_op_reg;
  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_cin     = alu_cin_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign flags       = flags_reg;
  assign dbg_data    = rf_reg[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a vector table of single instructions
// with hand-computed expectations, followed by hand-written sequences for
// back-to-back issue with instr_valid held high and reset during EXEC.
module tb_alu_issue_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [4:0]   instr_op;
  logic [1:0]   instr_rd, instr_rs1, instr_rs2;
  logic [N-1:0] instr_imm;
  logic [4:0]   alu_op;
  logic [N-1:0] alu_a, alu_b;
  logic         alu_cin;
  logic [N-1:0] alu_res;
  logic         alu_v, alu_c, alu_n, alu_z;
  logic         done, err;
  logic [3:0]   flags;
  logic [1:0]   dbg_addr;
  logic [N-1:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z),
    .done(done), .err(err), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic [7:0] res;        // ALU model result returned during EXEC
    logic [3:0] aflags;     // ALU model flags {V,C,N,Z}
    logic [7:0] exp_a, exp_b;
    logic       cin_chain;  // expected alu_cin when the carry chain is built in
    logic [7:0] exp_val;    // r[rd] after retirement
    logic [3:0] exp_flags;
    logic       exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_cin(input logic chain);
`ifdef ALU_CARRY_CHAIN_EN
    return chain;
`else
    return 1'b0 & chain;
`endif
  endfunction

  // Present one instruction at a negedge, follow it to retirement, check the result.
  task automatic run_vec(input vec_t v);
    logic is_alu;
    is_alu = (v.op <= 5'd14);
    @(negedge clk);
    check({v.name, " ready_before"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr_op = v.op; instr_rd = v.rd; instr_rs1 = v.rs1; instr_rs2 = v.rs2;
    instr_imm = v.imm;
    alu_res = v.res;
    {alu_v, alu_c, alu_n, alu_z} = v.aflags;
    dbg_addr = v.rd;
    @(posedge clk); #1;          // edge T: accepted
    instr_valid = 1'b0;
    if (is_alu) begin
      check({v.name, " exec_ready"}, instr_ready, 0);
      check({v.name, " exec_done"}, done, 0);
      check({v.name, " exec_op"}, alu_op, v.op);
      check({v.name, " exec_a"}, alu_a, v.exp_a);
      check({v.name, " exec_b"}, alu_b, v.exp_b);
      check({v.name, " exec_cin"}, alu_cin, exp_cin(v.cin_chain));
      @(posedge clk); #1;
    end else begin
      check({v.name, " wb_alu_op"}, alu_op, 0);
    end
    check({v.name, " wb_done"}, done, 1);
    check({v.name, " wb_err"}, err, v.exp_err);
    check({v.name, " wb_ready"}, instr_ready, 0);
    @(posedge clk); #1;
    check({v.name, " ret_ready"}, instr_ready, 1);
    check({v.name, " ret_done"}, done, 0);
    check({v.name, " ret_val"}, dbg_data, v.exp_val);
    check({v.name, " ret_flags"}, flags, v.exp_flags);
    $display("txn %-10s op=%0d rd=r%0d val=0x%02h flags=%b err_seen=%0b",
             v.name, v.op, v.rd, dbg_data, flags, v.exp_err);
  endtask

  initial begin
    //          name      op    rd    rs1   rs2   imm    res    aflg     a      b     cin   val    flags    err
    vecs[0] = '{"ldi_r1", 5'd31, 2'd1, 2'd0, 2'd0, 8'h7F, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h7F, 4'b0000, 1'b0};
    vecs[1] = '{"ldi_r2", 5'd31, 2'd2, 2'd0, 2'd0, 8'h01, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h01, 4'b0000, 1'b0};
    vecs[2] = '{"add_r3", 5'd0,  2'd3, 2'd1, 2'd2, 8'h00, 8'h80, 4'b1010, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1010, 1'b0};
    vecs[3] = '{"and_r0", 5'd4,  2'd0, 2'd1, 2'd2, 8'h00, 8'h01, 4'b0001, 8'h7F, 8'h01, 1'b0, 8'h01, 4'b1010, 1'b0};
    vecs[4] = '{"ill_20", 5'd20, 2'd1, 2'd0, 2'd0, 8'h55, 8'h33, 4'b1111, 8'h00, 8'h00, 1'b0, 8'h7F, 4'b1010, 1'b1};
    vecs[5] = '{"sub_r2", 5'd1,  2'd2, 2'd1, 2'd2, 8'h00, 8'h7E, 4'b0100, 8'h7F, 8'h01, 1'b0, 8'h7E, 4'b0100, 1'b0};
    vecs[6] = '{"addc_r0", 5'd0, 2'd0, 2'd0, 2'd2, 8'h00, 8'h7F, 4'b0000, 8'h01, 8'h7E, 1'b1, 8'h7F, 4'b0000, 1'b0};
    vecs[7] = '{"add_r1r1", 5'd0, 2'd1, 2'd1, 2'd1, 8'h00, 8'hFE, 4'b1010, 8'h7F, 8'h7F, 1'b0, 8'hFE, 4'b1010, 1'b0};
    vecs[8] = '{"ldi_r3", 5'd31, 2'd3, 2'd0, 2'd0, 8'hA5, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'hA5, 4'b1010, 1'b0};

    rst_n = 1'b0; instr_valid = 1'b0;
    instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
    alu_res = '0; {alu_v, alu_c, alu_n, alu_z} = 4'b0000; dbg_addr = 2'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_flags", flags, 0);
    check("rst_alu", {alu_op, alu_a, alu_b, alu_cin}, 0);
    check("rst_r0", dbg_data, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", instr_ready, 1);
    $display("txn reset      ready=%0b flags=%b", instr_ready, flags);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    // Illegal op must not have touched r1 (checked in its vector); verify r0 too
    dbg_addr = 2'd0; #1;
    check("r0_final", dbg_data, 8'h7F);

    // instr_valid held high: ADD r3,r1,r2 (a=FE, b=7E), accepted twice
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 5'd0; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
    alu_res = 8'h11; {alu_v, alu_c, alu_n, alu_z} = 4'b0001; dbg_addr = 2'd3;
    @(posedge clk); #1;                               // T+1
    check("bp_t1_ready", instr_ready, 0);
    check("bp_t1_a", alu_a, 8'hFE);
    @(posedge clk); #1;                               // T+2
    check("bp_t2_ready", instr_ready, 0);
    check("bp_t2_done", done, 1);
    @(posedge clk); #1;                               // T+3
    check("bp_t3_ready", instr_ready, 1);
    check("bp_t3_r3", dbg_data, 8'h11);
    check("bp_t3_flags", flags, 4'b0001);
    @(posedge clk); #1;                               // T+4: second accept took effect
    check("bp_t4_ready", instr_ready, 0);
    check("bp_t4_op_b", {alu_op, alu_b}, {5'd0, 8'h7E});
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_end_ready", instr_ready, 1);
    $display("txn backpress  r3=0x%02h flags=%b", dbg_data, flags);

    // Reset pulsed during EXEC of ADD r3
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 5'd0; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
    alu_res = 8'h99; {alu_v, alu_c, alu_n, alu_z} = 4'b1111;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("rx_exec_op", alu_a, 8'hFE);
    @(negedge clk); rst_n = 1'b0; #1;
    check("rx_ready_low", instr_ready, 0);
    check("rx_done_low", done, 0);
    check("rx_alu_low", {alu_op, alu_a, alu_b}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rx_ready", instr_ready, 1);
    check("rx_done", done, 0);
    check("rx_r3", dbg_data, 0);
    check("rx_flags", flags, 0);
    dbg_addr = 2'd1; #1;
    check("rx_r1", dbg_data, 0);
    $display("txn rst_exec   ready=%0b flags=%b", instr_ready, flags);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
